// File: rtl/sram_burst.sv
// rtl/sram_burst.sv - parametrised synchronous SRAM model with byte enables, read pipeline and burst addressing
module sram_burst #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 17,
    parameter int READ_LATENCY = 1,
    parameter int WRAP_LEN     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce_n,
    input  logic                    we_n,
    input  logic                    oe_n,
    input  logic [DATA_WIDTH/8-1:0] be_n,
    input  logic                    adv_n,
    input  logic [ADDR_WIDTH-1:0]   addr,
    inout  wire  [DATA_WIDTH-1:0]   data,
    output logic                    rvalid
);
    localparam int LANES  = DATA_WIDTH / 8;
    localparam int PIPE_W = READ_LATENCY * DATA_WIDTH;
    // Address bits that advance during a burst; a linear burst advances all of them.
    localparam logic [ADDR_WIDTH-1:0] WRAP_MASK =
        (WRAP_LEN == 0) ? {ADDR_WIDTH{1'b1}} : ADDR_WIDTH'(WRAP_LEN - 1);

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0]   burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]   ea, ea_inc;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [PIPE_W-1:0]       pipe_q, pipe_d;
    logic [DATA_WIDTH-1:0]   stage0_d;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   lane_mask;
    logic                    access, wr_access, rd_access, drive;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_mask[8*g +: 8] = {8{~be_n[g]}};
    end

    always_comb begin
        access    = !ce_n;
        wr_access = access && !we_n;
        rd_access = access && we_n;
        ea        = adv_n ? addr : burst_q;
        ea_inc    = ea + ADDR_WIDTH'(1);
        burst_d   = access ? ((ea & ~WRAP_MASK) | (ea_inc & WRAP_MASK)) : burst_q;
        // Bubbles keep stale stage-0 data; only the valid bit matters for them.
        stage0_d  = rd_access ? mem[ea] : pipe_q[DATA_WIDTH-1:0];
        vld_d     = READ_LATENCY'({vld_q, rd_access});
        pipe_d    = PIPE_W'({pipe_q, stage0_d});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
            vld_q   <= '0;
            pipe_q  <= '0;
        end else begin
            burst_q <= burst_d;
            vld_q   <= vld_d;
            pipe_q  <= pipe_d;
        end
    end

    // The array is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_access) begin
            mem[ea] <= (mem[ea] & ~lane_mask) | (data & lane_mask);
        end
    end

    assign rd_q   = pipe_q[PIPE_W-1 -: DATA_WIDTH];
    assign rvalid = vld_q[READ_LATENCY-1];
    assign drive  = !oe_n && rvalid && !wr_access;
    assign data   = drive ? rd_q : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_sram_burst.sv
// tb/tb_sram_burst.sv - directed table-driven bench for sram_burst (linear RL3 and wrap-4 RL1 instances)
module tb_sram_burst;
    // Released buses are pulled up, so high-Z reads back as all ones.
    localparam logic [15:0] IDLE = 16'hFFFF;

    typedef struct {
        logic        ce_n, we_n, oe_n, adv_n;
        logic [1:0]  be_n;
        logic [16:0] addr;
        logic [15:0] wd;
        logic        exp_va;
        logic [15:0] exp_da;
        logic        exp_vb;
        logic [15:0] exp_db;
        logic        chk_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_n, we_n, oe_n, adv_n, drv;
    logic [1:0]  be_n;
    logic [16:0] addr;
    logic [15:0] wd;
    wire  [15:0] data_a, data_b;
    wire         rvalid_a, rvalid_b;
    int          passed = 0;
    int          total  = 0;
    vec_t        tbl[$];
    vec_t        v;

    always #5 clk = ~clk;

    assign data_a = drv ? wd : 16'hzzzz;
    assign data_b = drv ? wd : 16'hzzzz;
    pullup (data_a);
    pullup (data_b);

    sram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(17), .READ_LATENCY(3), .WRAP_LEN(0)) u_a (
        .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n), .be_n(be_n),
        .adv_n(adv_n), .addr(addr), .data(data_a), .rvalid(rvalid_a)
    );

    sram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(17), .READ_LATENCY(1), .WRAP_LEN(4)) u_b (
        .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n), .be_n(be_n),
        .adv_n(adv_n), .addr(addr), .data(data_b), .rvalid(rvalid_b)
    );

    function automatic vec_t mk(logic ce, logic we, logic oe, logic adv, logic [1:0] be,
                                logic [16:0] a, logic [15:0] d, logic va, logic [15:0] da,
                                logic vb, logic [15:0] db);
        vec_t r;
        r.ce_n = ce; r.we_n = we; r.oe_n = oe; r.adv_n = adv; r.be_n = be;
        r.addr = a; r.wd = d; r.exp_va = va; r.exp_da = da; r.exp_vb = vb; r.exp_db = db;
        r.chk_b = 1'b1;
        return r;
    endfunction

    function automatic vec_t idle(logic va, logic [15:0] da, logic vb, logic [15:0] db);
        return mk(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 17'h0, 16'h0, va, da, vb, db);
    endfunction

    function automatic vec_t rd(logic adv, logic [16:0] a, logic oe,
                                logic va, logic [15:0] da, logic vb, logic [15:0] db);
        return mk(1'b0, 1'b1, oe, adv, 2'b11, a, 16'h0, va, da, vb, db);
    endfunction

    function automatic vec_t wr(logic adv, logic [16:0] a, logic [1:0] be, logic [15:0] d,
                                logic va, logic vb);
        return mk(1'b0, 1'b0, 1'b0, adv, be, a, d, va, d, vb, d);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic apply(input vec_t x, input string tag);
        ce_n = x.ce_n; we_n = x.we_n; oe_n = x.oe_n; adv_n = x.adv_n;
        be_n = x.be_n; addr = x.addr; wd = x.wd;
        drv  = !x.ce_n && !x.we_n;
        @(posedge clk);
        #2;
        check({tag, " rvalid_a"}, {15'b0, rvalid_a}, {15'b0, x.exp_va});
        check({tag, " data_a"}, data_a, x.exp_da);
        check({tag, " rvalid_b"}, {15'b0, rvalid_b}, {15'b0, x.exp_vb});
        if (x.chk_b) check({tag, " data_b"}, data_b, x.exp_db);
    endtask

    initial begin
        rst_n = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b0; adv_n = 1'b1;
        be_n = 2'b11; addr = '0; wd = '0; drv = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Instance a: RL=3 linear burst.  Instance b: RL=1, wrap length 4.
        tbl.push_back(idle(0, IDLE, 0, IDLE));
        tbl.push_back(wr(1, 17'h1FFFF, 2'b00, 16'h00A5, 0, 0));
        tbl.push_back(rd(1, 17'h1FFFF, 0, 0, IDLE, 1, 16'h00A5));
        tbl.push_back(rd(1, 17'h1FFFF, 1, 0, IDLE, 1, IDLE));
        tbl.push_back(wr(1, 17'h00010, 2'b00, 16'h1234, 1, 0));
        tbl.push_back(wr(1, 17'h00010, 2'b10, 16'hFFEE, 1, 0));
        tbl.push_back(rd(1, 17'h00010, 0, 0, IDLE, 1, 16'h12EE));
        tbl.push_back(idle(0, IDLE, 0, IDLE));
        tbl.push_back(idle(1, 16'h12EE, 0, IDLE));
        tbl.push_back(wr(1, 17'h1FFFE, 2'b00, 16'h1111, 0, 0));
        tbl.push_back(wr(0, 17'h0, 2'b00, 16'h2222, 0, 0));
        tbl.push_back(wr(0, 17'h0, 2'b00, 16'h3333, 0, 0));
        tbl.push_back(wr(0, 17'h0, 2'b00, 16'h4444, 0, 0));
        tbl.push_back(rd(1, 17'h1FFFE, 0, 0, IDLE, 1, 16'h1111));
        tbl.push_back(rd(0, 17'h0, 0, 0, IDLE, 1, 16'h2222));
        tbl.push_back(rd(0, 17'h0, 0, 1, 16'h1111, 1, 16'h3333));
        tbl.push_back(rd(0, 17'h0, 0, 1, 16'h2222, 1, 16'h4444));
        tbl.push_back(idle(1, 16'h3333, 0, IDLE));
        tbl.push_back(idle(1, 16'h4444, 0, IDLE));
        tbl.push_back(idle(0, IDLE, 0, IDLE));
        tbl.push_back(rd(1, 17'h00010, 0, 0, IDLE, 1, 16'h12EE));
        tbl.push_back(wr(1, 17'h00010, 2'b00, 16'hBEEF, 0, 0));
        tbl.push_back(idle(1, 16'h12EE, 0, IDLE));
        tbl.push_back(rd(1, 17'h00010, 0, 0, IDLE, 1, 16'hBEEF));
        tbl.push_back(idle(0, IDLE, 0, IDLE));
        tbl.push_back(idle(1, 16'hBEEF, 0, IDLE));

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], $sformatf("v%0d", k));

        // Reset with reads in flight: three reads, then a half-cycle reset pulse.
        apply(rd(1, 17'h00010, 0, 0, IDLE, 1, 16'hBEEF), "r0");
        apply(rd(1, 17'h1FFFE, 0, 0, IDLE, 1, 16'h1111), "r1");
        apply(rd(1, 17'h00010, 0, 1, 16'hBEEF, 1, 16'hBEEF), "r2");
        rst_n = 1'b0;
        #1;
        check("rst rvalid_a", {15'b0, rvalid_a}, 16'h0);
        check("rst rvalid_b", {15'b0, rvalid_b}, 16'h0);
        check("rst data_a", data_a, IDLE);
        check("rst data_b", data_b, IDLE);
        #4;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) apply(idle(0, IDLE, 0, IDLE), $sformatf("post%0d", k));

        v = rd(0, 17'h1FFFE, 0, 0, IDLE, 1, IDLE);
        v.chk_b = 1'b0;
        apply(v, "b0");
        apply(v, "b1");
        apply(idle(1, 16'h3333, 0, IDLE), "b2");
        apply(idle(1, 16'h4444, 0, IDLE), "b3");
        apply(idle(0, IDLE, 0, IDLE), "b4");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
